// File: rtl/pattern_match_pkg.sv
// Shared types and sizing helpers for the pattern stream matcher.
// Optional build macro used by the block: PATTERN_MASK_EN.
package pattern_match_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, HOLD, DONE} state_t;

  typedef struct packed {
    logic full;
    logic span;
    logic partial;
  } match_flags_t;

  function automatic int calc_wpl(input int cl_size, input int word_w);
    return (cl_size * 8) / word_w;
  endfunction

  function automatic int calc_off_w(input int wpl);
    return (wpl > 1) ? $clog2(wpl) : 1;
  endfunction

endpackage

// File: rtl/pattern_stream_matcher_if.sv
// Config, line and result handshake bundle for pattern_stream_matcher.
// PATTERN_MASK_EN adds the per-word don't-care mask input.
interface pattern_stream_matcher_if #(
  parameter int CL_SIZE = 64,
  parameter int WORD_W  = 32,
  parameter int PAT_MAX = 16,
  parameter int IDX_W   = 16
);
  localparam int WPL   = pattern_match_pkg::calc_wpl(CL_SIZE, WORD_W);
  localparam int OFF_W = pattern_match_pkg::calc_off_w(WPL);
  localparam int SZ_W  = $clog2(PAT_MAX) + 1;

  logic                      i_start;
  logic [PAT_MAX*WORD_W-1:0] i_cfg_pattern;
  logic [SZ_W-1:0]           i_cfg_size;
`ifdef PATTERN_MASK_EN
  logic [PAT_MAX-1:0]        i_cfg_mask;
`endif
  logic                      i_line_valid;
  logic                      o_line_ready;
  logic [CL_SIZE*8-1:0]      i_line_data;
  logic                      i_line_last;
  logic                      o_res_valid;
  logic                      i_res_ready;
  logic                      o_full_match;
  logic                      o_span_match;
  logic                      o_partial_match;
  logic [OFF_W-1:0]          o_match_offset;
  logic [IDX_W-1:0]          o_line_idx;
  logic                      o_busy;
  logic                      o_op_end;

  modport master (
`ifdef PATTERN_MASK_EN
    output i_cfg_mask,
`endif
    output i_start, i_cfg_pattern, i_cfg_size, i_line_valid, i_line_data,
           i_line_last, i_res_ready,
    input  o_line_ready, o_res_valid, o_full_match, o_span_match,
           o_partial_match, o_match_offset, o_line_idx, o_busy, o_op_end
  );

  modport slave (
`ifdef PATTERN_MASK_EN
    input  i_cfg_mask,
`endif
    input  i_start, i_cfg_pattern, i_cfg_size, i_line_valid, i_line_data,
           i_line_last, i_res_ready,
    output o_line_ready, o_res_valid, o_full_match, o_span_match,
           o_partial_match, o_match_offset, o_line_idx, o_busy, o_op_end
  );
endinterface

// File: rtl/pattern_stream_matcher_word_cmp_array.sv
// Combinational WPL x PAT_MAX equality matrix: eq[i*PAT_MAX+j] = line word i vs pattern word j.
// A set mask bit turns that pattern word into a don't-care for every line word.
module word_cmp_array #(
  parameter int WPL     = 16,
  parameter int WORD_W  = 32,
  parameter int PAT_MAX = 16
) (
  input  logic [WPL*WORD_W-1:0]     line_data,
  input  logic [PAT_MAX*WORD_W-1:0] pat_data,
  input  logic [PAT_MAX-1:0]        mask,
  output logic [WPL*PAT_MAX-1:0]    eq
);
  generate
    for (genvar gi = 0; gi < WPL; gi++) begin : g_line
      for (genvar gj = 0; gj < PAT_MAX; gj++) begin : g_pat
        assign eq[gi*PAT_MAX+gj] = mask[gj] |
          (line_data[gi*WORD_W +: WORD_W] == pat_data[gj*WORD_W +: WORD_W]);
      end
    end
  endgenerate
endmodule

// File: rtl/pattern_stream_matcher.sv
// Streaming pattern search over cache lines, including matches straddling two lines.
// Build option: PATTERN_MASK_EN enables per-word don't-care masking of the pattern.
module pattern_stream_matcher
  import pattern_match_pkg::*;
#(
  parameter int CL_SIZE = 64,
  parameter int WORD_W  = 32,
  parameter int PAT_MAX = 16,
  parameter int IDX_W   = 16
) (
  input logic                    i_clk,
  input logic                    i_rst,
  pattern_stream_matcher_if.slave bus
);
  localparam int WPL   = calc_wpl(CL_SIZE, WORD_W);
  localparam int OFF_W = calc_off_w(WPL);
  localparam int SZ_W  = $clog2(PAT_MAX) + 1;

  state_t                    state, state_next;
  logic [PAT_MAX*WORD_W-1:0] pat_reg;
  logic [SZ_W-1:0]           size_reg;
  logic [PAT_MAX-1:0]        mask_reg, mask_in;
  logic [PAT_MAX-1:0]        carry_reg, carry_next;
  logic [IDX_W-1:0]          idx_cnt_reg, idx_reg;
  logic                      last_reg, res_valid_reg, op_end_reg;
  match_flags_t              flags_reg, flags_next;
  logic [OFF_W-1:0]          off_reg, off_next;
  logic [WPL*PAT_MAX-1:0]    eq;
  logic [WPL-1:0]            inline_hit;
  logic [PAT_MAX-1:0]        span_hit;
  logic                      size_ok, accept, take, start_ok;

`ifdef PATTERN_MASK_EN
  assign mask_in = bus.i_cfg_mask;
`else
  assign mask_in = '0;
`endif

  assign start_ok = bus.i_start && (state == IDLE || state == DONE);
  assign accept   = bus.i_line_valid && (state == SCAN);
  assign take     = bus.i_res_ready && (state == HOLD);
  assign size_ok  = (size_reg != '0) && (int'(size_reg) <= PAT_MAX);

  word_cmp_array #(.WPL(WPL), .WORD_W(WORD_W), .PAT_MAX(PAT_MAX)) u_cmp (
    .line_data (bus.i_line_data),
    .pat_data  (pat_reg),
    .mask      (mask_reg),
    .eq        (eq)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.i_start) state_next = SCAN;
      SCAN:    if (bus.i_line_valid) state_next = HOLD;
      HOLD:    if (bus.i_res_ready) state_next = last_reg ? DONE : SCAN;
      DONE:    if (bus.i_start) state_next = SCAN;
      default: state_next = IDLE;
    endcase
  end

  // Match evaluation on the presented line against the latched pattern and carry.
  always_comb begin
    inline_hit = '0;
    span_hit   = '0;
    carry_next = '0;
    flags_next = '0;
    off_next   = '0;
    for (int o = 0; o < WPL; o++) begin
      inline_hit[o] = (o + int'(size_reg) <= WPL);
      for (int j = 0; j < PAT_MAX; j++) begin
        if (j < int'(size_reg)) begin
          if (o + j < WPL) inline_hit[o] = inline_hit[o] & eq[(o+j)*PAT_MAX + j];
          else             inline_hit[o] = 1'b0;
        end
      end
    end
    for (int k = 0; k < PAT_MAX; k++) begin
      span_hit[k]   = (k != 0) && carry_reg[k];
      carry_next[k] = (k != 0) && (k < int'(size_reg));
      for (int j = 0; j < PAT_MAX; j++) begin
        if ((j + k < PAT_MAX) && (j + k < int'(size_reg)))
          span_hit[k] = span_hit[k] & eq[j*PAT_MAX + (k+j)];
        if (j < k && k < WPL)
          carry_next[k] = carry_next[k] & eq[(WPL-k+j)*PAT_MAX + j];
      end
    end
    if (!size_ok) begin
      inline_hit = '0;
      span_hit   = '0;
      carry_next = '0;
    end
    // Earliest start wins: lowest in-line offset, overridden by the longest carried prefix.
    for (int o = WPL - 1; o >= 0; o--) begin
      if (inline_hit[o]) begin
        flags_next.full = 1'b1;
        off_next        = OFF_W'(o);
      end
    end
    for (int k = 1; k < PAT_MAX; k++) begin
      if (span_hit[k]) begin
        flags_next.full = 1'b1;
        flags_next.span = 1'b1;
        off_next        = OFF_W'(WPL - k);
      end
    end
    flags_next.partial = |carry_next;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pat_reg       <= '0;
      size_reg      <= '0;
      mask_reg      <= '0;
      carry_reg     <= '0;
      idx_cnt_reg   <= '0;
      idx_reg       <= '0;
      last_reg      <= 1'b0;
      res_valid_reg <= 1'b0;
      op_end_reg    <= 1'b0;
      flags_reg     <= '0;
      off_reg       <= '0;
    end else begin
      if (start_ok) begin
        pat_reg     <= bus.i_cfg_pattern;
        size_reg    <= bus.i_cfg_size;
        mask_reg    <= mask_in;
        carry_reg   <= '0;
        idx_cnt_reg <= '0;
        op_end_reg  <= 1'b0;
      end
      if (accept) begin
        flags_reg     <= flags_next;
        off_reg       <= off_next;
        idx_reg       <= idx_cnt_reg;
        idx_cnt_reg   <= idx_cnt_reg + 1'b1;
        carry_reg     <= carry_next;
        last_reg      <= bus.i_line_last;
        res_valid_reg <= 1'b1;
      end
      if (take) begin
        res_valid_reg <= 1'b0;
        if (last_reg) op_end_reg <= 1'b1;
      end
    end
  end

  assign bus.o_line_ready    = (state == SCAN);
  assign bus.o_busy          = (state == SCAN) || (state == HOLD);
  assign bus.o_op_end        = op_end_reg;
  assign bus.o_res_valid     = res_valid_reg;
  assign bus.o_full_match    = flags_reg.full;
  assign bus.o_span_match    = flags_reg.span;
  assign bus.o_partial_match = flags_reg.partial;
  assign bus.o_match_offset  = off_reg;
  assign bus.o_line_idx      = idx_reg;

endmodule
